// File: rtl/seg7_scan_controller.sv
// -----------------------------------------------------------------------------
// seg7_scan_controller
//
// Time-multiplexing scheduler for an 8-digit seven-segment display.
//
// The controller owns one 32-bit display word, which is 8 hex nibbles. It
// scans the word one digit per refresh slot. For each slot it feeds the
// selected nibble and the digit index into the downstream combinational
// decoder.
//
// Each slot opens with an optional blanking interval to prevent ghosting.
// A digit whose enable bit is low stays blanked for its whole slot.
//
// New words arrive over a valid/ready handshake. Only one word can be pending
// at a time. A pending word is promoted to the displayed word at a frame
// boundary, so every digit of a frame comes from the same word.
//
// Ports
//   clk           in   1   system clock, rising edge
//   reset         in   1   synchronous, active-high reset
//   load_valid    in   1   load_data is valid
//   load_ready    out  1   controller can accept a word (pending slot empty)
//   load_data     in   32  display word; nibble k -> digit k
//   digit_en      in   8   per-digit enable; 0 blanks that digit for its slot
//   digit_nibble  out  4   nibble of the currently selected digit
//   digit_sel     out  3   currently scanned digit index
//   blank         out  1   1 = force all anodes/segments off
//   frame_done    out  1   1-cycle pulse on the last cycle of the last slot
// -----------------------------------------------------------------------------
module seg7_scan_controller #(
  parameter int REFRESH_DIV = 100000,  // clk cycles per digit slot, >= 2
  parameter int BLANK_CYC   = 1000,    // blanked cycles at slot start, 0..REFRESH_DIV-1
  parameter int N_DIGITS    = 8        // digits scanned, 1..8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  digit_en,
  output logic [3:0]  digit_nibble,
  output logic [2:0]  digit_sel,
  output logic        blank,
  output logic        frame_done
);

  localparam int               DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       SEL_LAST = 3'(N_DIGITS - 1);

  // Phase within a slot: the blanking prefix, then the visible remainder.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic [2:0]       digit_sel_reg;
  logic [2:0]       digit_sel_next;
  slot_state_t      state_reg;
  slot_state_t      state_next;

  // Enable bit of the digit being shown, captured together with the slot
  // state. This keeps blank a pure decode of flops.
  logic             en_ok_reg;
  logic             frame_done_reg;

  logic [31:0]      active_reg;
  logic [31:0]      pending_reg;
  logic             pending_valid_reg;

  logic             slot_wrap;
  logic             frame_end;
  logic             in_blank_next;

  // ---------------------------------------------------------------------------
  // Slot counter and digit index (next-state logic)
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_wrap      = (div_cnt_reg == DIV_LAST);
    frame_end      = slot_wrap && (digit_sel_reg == SEL_LAST);
    div_cnt_next   = slot_wrap ? '0 : div_cnt_reg + 1'b1;
    digit_sel_next = digit_sel_reg;
    if (slot_wrap) begin
      // The digit index advances in the same cycle that the counter returns
      // to 0. It never reaches N_DIGITS.
      digit_sel_next = (digit_sel_reg == SEL_LAST) ? 3'd0 : digit_sel_reg + 3'd1;
    end
  end

  // Blanking prefix of the upcoming cycle. With no blanking configured, the
  // comparison would be constant-false, so it is elaborated away.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank_next = 1'b0;
    end else begin : g_blank
      assign in_blank_next = (div_cnt_next < DIV_W'(BLANK_CYC));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Slot FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = in_blank_next ? ST_BLANK : ST_SHOW;
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: state register (with the scan counters)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_BLANK;
      div_cnt_reg    <= '0;
      digit_sel_reg  <= 3'd0;
      en_ok_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      digit_sel_reg  <= digit_sel_next;
      en_ok_reg      <= digit_en[digit_sel_next];
      frame_done_reg <= (div_cnt_next == DIV_LAST) && (digit_sel_next == SEL_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Word handshake and frame-boundary promotion
  //
  // load_ready is simply "pending slot empty". Because of that, a transfer and
  // a promotion can never both hit the pending register in the same cycle.
  // A word accepted on the boundary cycle itself waits a full frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg        <= 32'd0;
      pending_reg       <= 32'd0;
      pending_valid_reg <= 1'b0;
    end else begin
      if (frame_end && pending_valid_reg) begin
        active_reg        <= pending_reg;
        pending_valid_reg <= 1'b0;
      end else if (load_valid && !pending_valid_reg) begin
        pending_reg       <= load_data;
        pending_valid_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble selection
  // ---------------------------------------------------------------------------
  logic [3:0] nibble_arr [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign nibble_arr[gi] = active_reg[4*gi +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_sel    = digit_sel_reg;
    digit_nibble = nibble_arr[digit_sel_reg];  // valid even while blanked
    blank        = (state_reg == ST_BLANK) || !en_ok_reg;
    load_ready   = !pending_valid_reg;
    frame_done   = frame_done_reg;
  end

endmodule
